// File: rtl/pipe4_alu_param.sv
// Four-stage register/ALU/memory pipeline: S1 operand fetch, S2 ALU,
// S3 register writeback, S4 memory write. Single clock, valid/stall
// handshake, optional RAW bypass, register preload and debug read ports.
module pipe4_alu_param #(
    parameter int WIDTH     = 16,
    parameter int NREG      = 16,
    parameter int MEM_DEPTH = 256,
    parameter int FORWARD   = 1,
    localparam int RA_W     = $clog2(NREG),
    localparam int MA_W     = $clog2(MEM_DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             VALID_IN,
    input  logic             STALL,
    input  logic [RA_W-1:0]  rs1,
    input  logic [RA_W-1:0]  rs2,
    input  logic [RA_W-1:0]  rd,
    input  logic [3:0]       func,
    input  logic [MA_W-1:0]  addr,
    input  logic             LD_EN,
    input  logic [RA_W-1:0]  LD_REG,
    input  logic [WIDTH-1:0] LD_DATA,
    input  logic [RA_W-1:0]  DBG_RADDR,
    output logic [WIDTH-1:0] DBG_RDATA,
    input  logic [MA_W-1:0]  MEM_RADDR,
    output logic [WIDTH-1:0] MEM_RDATA,
    output logic [WIDTH-1:0] Zout,
    output logic             Z_VALID
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [RA_W-1:0]  rd;
        logic [3:0]       func;
        logic [MA_W-1:0]  addr;
    } s1_t;

    // vld_pipe[1] = S1, [2] = S2 (Zout), [3] = S3
    logic [3:1]       vld_pipe;
    s1_t              s1;
    logic [RA_W-1:0]  s2_rd;
    logic [MA_W-1:0]  s2_addr;
    logic [WIDTH-1:0] s3_z;
    logic [MA_W-1:0]  s3_addr;

    logic [WIDTH-1:0] reg_bank [NREG];
    logic [WIDTH-1:0] mem [MEM_DEPTH];

    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    // ALU on the S1 operands; everything truncates to WIDTH
    always_comb begin
        alu_y = '0;
        case (s1.func)
            4'd0:    alu_y = s1.a + s1.b;
            4'd1:    alu_y = s1.a - s1.b;
            4'd2:    alu_y = s1.a * s1.b;
            4'd3:    alu_y = s1.a;
            4'd4:    alu_y = s1.b;
            4'd5:    alu_y = s1.a & s1.b;
            4'd6:    alu_y = s1.a | s1.b;
            4'd7:    alu_y = s1.a ^ s1.b;
            4'd8:    alu_y = -s1.a;
            4'd9:    alu_y = -s1.b;
            4'd10:   alu_y = {s1.a[WIDTH-1], s1.a[WIDTH-1:1]};
            4'd11:   alu_y = {s1.a[WIDTH-2:0], 1'b0};
            default: alu_y = '0;
        endcase
    end

    // Operand fetch: youngest in-flight producer wins, then the register file.
    // Preloads are never bypassed; they only reach later issues via reg_bank.
    always_comb begin
        op_a = reg_bank[rs1];
        op_b = reg_bank[rs2];
        if (FORWARD != 0) begin
            if (vld_pipe[1] && s1.rd == rs1)      op_a = alu_y;
            else if (vld_pipe[2] && s2_rd == rs1) op_a = Zout;
            if (vld_pipe[1] && s1.rd == rs2)      op_b = alu_y;
            else if (vld_pipe[2] && s2_rd == rs2) op_b = Zout;
        end
    end

    // Stage registers; a stall freezes every stage and drops VALID_IN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_pipe <= '0;
            s1       <= '0;
            Zout     <= '0;
            s2_rd    <= '0;
            s2_addr  <= '0;
            s3_z     <= '0;
            s3_addr  <= '0;
        end else if (!STALL) begin
            vld_pipe <= {vld_pipe[2:1], VALID_IN};
            s1.a     <= op_a;
            s1.b     <= op_b;
            s1.rd    <= rd;
            s1.func  <= func;
            s1.addr  <= addr;
            Zout     <= alu_y;
            s2_rd    <= s1.rd;
            s2_addr  <= s1.addr;
            s3_z     <= Zout;
            s3_addr  <= s2_addr;
        end
    end

    // Register file: preload first so a same-cycle S2 writeback overrides it
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) reg_bank[i] <= '0;
        end else begin
            if (LD_EN)                 reg_bank[LD_REG] <= LD_DATA;
            if (!STALL && vld_pipe[2]) reg_bank[s2_rd]  <= Zout;
        end
    end

    // Data memory is not reset; writes are held off during stall and reset
    always_ff @(posedge CLK) begin
        if (RST_N && !STALL && vld_pipe[3]) mem[s3_addr] <= s3_z;
    end

    assign DBG_RDATA = reg_bank[DBG_RADDR];
    assign MEM_RDATA = mem[MEM_RADDR];
    assign Z_VALID   = vld_pipe[2];

endmodule

// File: tb/tb_pipe4_alu_param.sv
// Bench for pipe4_alu_param: one bypassing and one non-bypassing instance
// share stimulus; an issue-indexed reference model predicts both.
module tb_pipe4_alu_param;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        stall;
    logic [3:0]  rs1, rs2, rd, func, ld_reg, dbg_raddr;
    logic [7:0]  addr, mem_raddr;
    logic        ld_en;
    logic [15:0] ld_data;
    logic [15:0] dbg0, dbg1, memr0, memr1, zout0, zout1;
    logic        zv0, zv1;

    int tests;
    int fails;

    // reference model: results indexed by accepted-edge number
    bit          rec_v    [4096];
    logic [15:0] rec_r0   [4096];
    logic [15:0] rec_r1   [4096];
    logic [3:0]  rec_rd   [4096];
    logic [7:0]  rec_addr [4096];
    logic [15:0] rf0 [16];
    logic [15:0] rf1 [16];
    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    bit          known [256];
    int          n;
    logic [15:0] op_exp [16];
    logic [15:0] v0, v1;

    pipe4_alu_param #(.WIDTH(16), .NREG(16), .MEM_DEPTH(256), .FORWARD(1)) u_f1 (
        .CLK(clk), .RST_N(rst_n), .VALID_IN(valid_in), .STALL(stall),
        .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
        .LD_EN(ld_en), .LD_REG(ld_reg), .LD_DATA(ld_data),
        .DBG_RADDR(dbg_raddr), .DBG_RDATA(dbg1),
        .MEM_RADDR(mem_raddr), .MEM_RDATA(memr1),
        .Zout(zout1), .Z_VALID(zv1)
    );

    pipe4_alu_param #(.WIDTH(16), .NREG(16), .MEM_DEPTH(256), .FORWARD(0)) u_f0 (
        .CLK(clk), .RST_N(rst_n), .VALID_IN(valid_in), .STALL(stall),
        .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
        .LD_EN(ld_en), .LD_REG(ld_reg), .LD_DATA(ld_data),
        .DBG_RADDR(dbg_raddr), .DBG_RDATA(dbg0),
        .MEM_RADDR(mem_raddr), .MEM_RDATA(memr0),
        .Zout(zout0), .Z_VALID(zv0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return 16'((32'(a) * 32'(b)) & 32'h0000FFFF);
            4'd3:    return a;
            4'd4:    return b;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return 16'd0 - a;
            4'd9:    return 16'd0 - b;
            4'd10:   return (a >> 1) | (a & 16'h8000);
            4'd11:   return a << 1;
            default: return 16'd0;
        endcase
    endfunction

    // operand as the architecture defines it: newest valid in-flight producer
    // (issued one or two accepted edges earlier) if bypassing, else committed file
    function automatic logic [15:0] opnd(input bit fwd, input logic [3:0] r);
        if (fwd) begin
            if (rec_v[n-1] && rec_rd[n-1] == r) return rec_r1[n-1];
            if (rec_v[n-2] && rec_rd[n-2] == r) return rec_r1[n-2];
            return rf1[r];
        end
        return rf0[r];
    endfunction

    // one clock edge: advance model, then check Zout/Z_VALID of both DUTs
    task automatic tick();
        logic [15:0] a0, b0, a1, b1;
        a0 = opnd(1'b0, rs1);
        b0 = opnd(1'b0, rs2);
        a1 = opnd(1'b1, rs1);
        b1 = opnd(1'b1, rs2);
        @(posedge clk);
        #1;
        if (ld_en) begin
            rf0[ld_reg] = ld_data;
            rf1[ld_reg] = ld_data;
        end
        if (!stall) begin
            rec_v[n]    = valid_in;
            rec_rd[n]   = rd;
            rec_addr[n] = addr;
            rec_r0[n]   = alu_ref(func, a0, b0);
            rec_r1[n]   = alu_ref(func, a1, b1);
            if (rec_v[n-2]) begin
                rf0[rec_rd[n-2]] = rec_r0[n-2];
                rf1[rec_rd[n-2]] = rec_r1[n-2];
            end
            if (rec_v[n-3]) begin
                mem0[rec_addr[n-3]]  = rec_r0[n-3];
                mem1[rec_addr[n-3]]  = rec_r1[n-3];
                known[rec_addr[n-3]] = 1'b1;
            end
            n++;
        end
        chk("zvalid_f1", 16'(zv1), 16'(rec_v[n-2]));
        chk("zvalid_f0", 16'(zv0), 16'(rec_v[n-2]));
        if (rec_v[n-2]) begin
            chk("zout_f1", zout1, rec_r1[n-2]);
            chk("zout_f0", zout0, rec_r0[n-2]);
        end
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                         input logic [3:0] f, input logic [7:0] ad);
        valid_in = 1'b1; rs1 = a; rs2 = b; rd = d; func = f; addr = ad;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic bubble();
        valid_in = 1'b0;
        tick();
    endtask

    task automatic preload(input logic [3:0] r, input logic [15:0] d);
        ld_en = 1'b1; ld_reg = r; ld_data = d;
        bubble();
        ld_en = 1'b0;
    endtask

    task automatic preload_ident();
        for (int i = 0; i < 16; i++) preload(4'(i), 16'(i));
    endtask

    task automatic rd_reg(input logic [3:0] r, output logic [15:0] o0, output logic [15:0] o1);
        dbg_raddr = r;
        #1;
        o0 = dbg0;
        o1 = dbg1;
    endtask

    task automatic rd_mem(input logic [7:0] a, output logic [15:0] o0, output logic [15:0] o1);
        mem_raddr = a;
        #1;
        o0 = memr0;
        o1 = memr1;
    endtask

    // full register/memory comparison while the pipeline is frozen
    task automatic sweep();
        logic [15:0] s0, s1;
        valid_in = 1'b0;
        stall    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_reg(4'(i), s0, s1);
            chk("reg_f0", s0, rf0[i]);
            chk("reg_f1", s1, rf1[i]);
        end
        for (int i = 0; i < 256; i++) begin
            if (known[i]) begin
                rd_mem(8'(i), s0, s1);
                chk("mem_f0", s0, mem0[i]);
                chk("mem_f1", s1, mem1[i]);
            end
        end
        @(negedge clk);
        stall = 1'b0;
    endtask

    // asynchronous reset between edges; everything in flight is dropped
    task automatic mid_reset();
        logic [15:0] s0, s1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_zvalid_f1", 16'(zv1), 16'd0);
        chk("rst_zvalid_f0", 16'(zv0), 16'd0);
        chk("rst_zout_f1", zout1, 16'd0);
        chk("rst_zout_f0", zout0, 16'd0);
        for (int i = 0; i < 16; i++) begin
            rd_reg(4'(i), s0, s1);
            chk("rst_reg_f0", s0, 16'd0);
            chk("rst_reg_f1", s1, 16'd0);
        end
        for (int k = 1; k <= 3; k++) rec_v[n-k] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rf0[i] = 16'd0;
            rf1[i] = 16'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0; fails = 0; n = 3;
        rst_n = 1'b0; valid_in = 1'b0; stall = 1'b0; ld_en = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; func = '0; addr = '0;
        ld_reg = '0; ld_data = '0; dbg_raddr = '0; mem_raddr = '0;
        for (int i = 0; i < 16; i++) begin rf0[i] = '0; rf1[i] = '0; end
        op_exp = '{16'h8004, 16'h7FFE, 16'h8003, 16'h8001, 16'h0003, 16'h0001,
                   16'h8003, 16'h8002, 16'h7FFF, 16'hFFFD, 16'hC000, 16'h0002,
                   16'h0000, 16'h0000, 16'h0000, 16'h0000};

        // reset state
        #3;
        chk("init_zvalid", 16'(zv1), 16'd0);
        chk("init_zout", zout1, 16'd0);
        for (int i = 0; i < 16; i++) begin
            rd_reg(4'(i), v0, v1);
            chk("init_reg", v1, 16'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // 1: basic issue latency
        preload_ident();
        issue(4'd3, 4'd5, 4'd10, 4'd0, 8'd10);
        bubble();
        chk("t1_zout", zout1, 16'd8);
        chk("t1_zvalid", 16'(zv1), 16'd1);
        bubble();
        rd_reg(4'd10, v0, v1);
        chk("t1_reg_f0", v0, 16'd8);
        chk("t1_reg_f1", v1, 16'd8);
        bubble();
        rd_mem(8'd10, v0, v1);
        chk("t1_mem_f0", v0, 16'd8);
        chk("t1_mem_f1", v1, 16'd8);

        // 2: back-to-back RAW
        preload_ident();
        issue(4'd3, 4'd5, 4'd10, 4'd0, 8'd20);
        issue(4'd10, 4'd3, 4'd1, 4'd1, 8'd21);
        bubble();
        chk("t2_fwd", zout1, 16'd5);
        chk("t2_stale", zout0, 16'd7);
        repeat (3) bubble();

        // 3: distance-2 and distance-3 RAW
        preload_ident();
        issue(4'd3, 4'd5, 4'd10, 4'd0, 8'd22);
        bubble();
        issue(4'd10, 4'd2, 4'd2, 4'd2, 8'd23);
        bubble();
        chk("t3_d2_f1", zout1, 16'd16);
        repeat (2) bubble();
        preload_ident();
        issue(4'd3, 4'd5, 4'd10, 4'd0, 8'd24);
        bubble();
        bubble();
        issue(4'd10, 4'd2, 4'd2, 4'd2, 8'd25);
        bubble();
        chk("t3_d3_f1", zout1, 16'd16);
        chk("t3_d3_f0", zout0, 16'd16);
        repeat (3) bubble();

        // 4: stall mid-stream, with a would-be instruction presented while stalled
        preload_ident();
        issue(4'd3, 4'd5, 4'd7, 4'd0, 8'd40);
        issue(4'd7, 4'd1, 4'd8, 4'd0, 8'd41);
        stall = 1'b1; valid_in = 1'b1; rs1 = 4'd0; rs2 = 4'd0; rd = 4'd9; func = 4'd3; addr = 8'd43;
        tick();
        tick();
        stall = 1'b0; valid_in = 1'b0;
        issue(4'd8, 4'd8, 4'd9, 4'd0, 8'd42);
        repeat (4) bubble();
        rd_reg(4'd9, v0, v1);
        chk("t4_r9", v1, 16'd18);
        rd_mem(8'd42, v0, v1);
        chk("t4_mem42", v1, 16'd18);
        sweep();

        // 5: preload/writeback collision, then reset with writes pending
        preload_ident();
        issue(4'd3, 4'd6, 4'd4, 4'd0, 8'd30);
        bubble();
        ld_en = 1'b1; ld_reg = 4'd4; ld_data = 16'h1234;
        tick();
        ld_en = 1'b0;
        rd_reg(4'd4, v0, v1);
        chk("t5_collide_f0", v0, 16'h0009);
        chk("t5_collide_f1", v1, 16'h0009);
        issue(4'd1, 4'd2, 4'd5, 4'd0, 8'd10);
        issue(4'd3, 4'd4, 4'd6, 4'd0, 8'd10);
        bubble();
        mid_reset();
        repeat (3) bubble();
        rd_mem(8'd10, v0, v1);
        chk("t5_nowrite_f0", v0, 16'd8);
        chk("t5_nowrite_f1", v1, 16'd8);
        sweep();

        // 6: opcode sweep
        preload(4'd1, 16'h8001);
        preload(4'd2, 16'h0003);
        for (int f = 0; f < 16; f++) begin
            issue(4'd1, 4'd2, 4'd15, 4'(f), 8'(100 + f));
            bubble();
            chk("t6_op_f1", zout1, op_exp[f]);
            chk("t6_op_f0", zout0, op_exp[f]);
        end
        repeat (3) bubble();

        // random traffic with stalls
        for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));
        repeat (3) bubble();
        for (int i = 0; i < 400; i++) begin
            valid_in = ($urandom_range(3) != 0);
            stall    = ($urandom_range(7) == 0);
            rs1      = 4'($urandom);
            rs2      = 4'($urandom);
            rd       = 4'($urandom);
            func     = 4'($urandom);
            addr     = 8'($urandom);
            tick();
        end
        stall = 1'b0;
        repeat (4) bubble();
        sweep();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
